// File: rtl/id_ex_issue_pkg.sv
// id_ex_issue_pkg
// Shared widths, ALU op encodings, funct codes and the ID/EX pipeline
// register layout used by the ID/EX issue stage and its forwarding muxes.
//   DATA_WIDTH       : operand width
//   FIELD_WIDTH_FUNC : funct field width
//   REG_ADDR_WIDTH   : register index width
package id_ex_issue_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int FIELD_WIDTH_FUNC = 6;
  localparam int REG_ADDR_WIDTH   = 5;

  // ALU operation class handed to the ALU together with the funct code.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10
  } alu_op_e;

  // R-type funct codes understood by the ALU.
  localparam logic [FIELD_WIDTH_FUNC-1:0] FUNCT_ADD = 6'h20;
  localparam logic [FIELD_WIDTH_FUNC-1:0] FUNCT_SUB = 6'h22;
  localparam logic [FIELD_WIDTH_FUNC-1:0] FUNCT_AND = 6'h24;
  localparam logic [FIELD_WIDTH_FUNC-1:0] FUNCT_OR  = 6'h25;
  localparam logic [FIELD_WIDTH_FUNC-1:0] FUNCT_SLT = 6'h2a;

  // Contents of the ID/EX pipeline register.
  typedef struct packed {
    logic                        valid;
    logic [REG_ADDR_WIDTH-1:0]   rs;
    logic [REG_ADDR_WIDTH-1:0]   rt;
    logic [REG_ADDR_WIDTH-1:0]   wb_rd;
    logic [DATA_WIDTH-1:0]       rs_data;
    logic [DATA_WIDTH-1:0]       rt_data;
    logic [DATA_WIDTH-1:0]       imm;
    alu_op_e                     op;
    logic [FIELD_WIDTH_FUNC-1:0] fcn;
    logic                        alu_src;
    logic                        reg_write;
    logic                        mem_read;
    logic                        mem_write;
    logic                        mem_to_reg;
  } ex_reg_t;

  // A bubble is an all-zero register: invalid, no controls, indices 0, data 0.
  localparam ex_reg_t EX_BUBBLE = '0;

endpackage

// File: rtl/id_ex_issue_fwd_mux.sv
// fwd_mux
// Priority forwarding select for one EX-stage source register.
//   idx            : register index read by the EX instruction
//   reg_data       : value captured from the register file in decode
//   exmem_*        : EX/MEM forward source (highest priority)
//   memwb_*        : MEM/WB forward source
//   value          : forwarded operand value
module fwd_mux
  import id_ex_issue_pkg::*;
(
  input  logic [REG_ADDR_WIDTH-1:0] idx,
  input  logic [DATA_WIDTH-1:0]     reg_data,
  input  logic                      exmem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] exmem_rd,
  input  logic [DATA_WIDTH-1:0]     exmem_result,
  input  logic                      memwb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] memwb_rd,
  input  logic [DATA_WIDTH-1:0]     memwb_result,
  output logic [DATA_WIDTH-1:0]     value
);

  logic idx_nonzero;

  // Register 0 is hardwired to zero, so a write "to" it must never be forwarded.
  assign idx_nonzero = (idx != '0);

  // The younger EX/MEM result overrides MEM/WB, which overrides the stale read.
  always_comb begin
    value = reg_data;
    if (memwb_reg_write && idx_nonzero && (memwb_rd == idx))
      value = memwb_result;
    if (exmem_reg_write && idx_nonzero && (exmem_rd == idx))
      value = exmem_result;
  end

endmodule

// File: rtl/id_ex_issue.sv
// id_ex_issue
// ID/EX pipeline stage feeding the ALU. Registers decoded operands and
// controls, forwards EX/MEM and MEM/WB results onto the operand buses,
// selects the immediate, detects load-use hazards (stall + bubble) and
// counts stall cycles.
//   clk_87, rst_n_87      : clock, asynchronous active-low reset
//   id_*                  : decoded instruction from the decode stage
//   flush_87              : squash the decode instruction
//   exmem_*, memwb_*      : forwarding sources
//   stall_87              : hold PC and IF/ID
//   ex_valid_87, arg_*, op_87, fcn_87 : ALU interface
//   ex_store_data_87, ex_wb_rd_87, ex_*_87 : downstream data and controls
//   stall_count_87        : saturating stall-cycle count
module id_ex_issue
  import id_ex_issue_pkg::*;
(
  input  logic                        clk_87,
  input  logic                        rst_n_87,
  input  logic                        id_valid_87,
  input  logic [DATA_WIDTH-1:0]       id_rs_data_87,
  input  logic [DATA_WIDTH-1:0]       id_rt_data_87,
  input  logic [DATA_WIDTH-1:0]       id_imm_87,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rs_87,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rt_87,
  input  logic [REG_ADDR_WIDTH-1:0]   id_rd_87,
  input  logic [1:0]                  id_alu_op_87,
  input  logic [FIELD_WIDTH_FUNC-1:0] id_fcn_87,
  input  logic                        id_alu_src_87,
  input  logic                        id_reg_dst_87,
  input  logic                        id_reg_write_87,
  input  logic                        id_mem_read_87,
  input  logic                        id_mem_write_87,
  input  logic                        id_mem_to_reg_87,
  input  logic                        flush_87,
  input  logic                        exmem_reg_write_87,
  input  logic [REG_ADDR_WIDTH-1:0]   exmem_rd_87,
  input  logic [DATA_WIDTH-1:0]       exmem_result_87,
  input  logic                        memwb_reg_write_87,
  input  logic [REG_ADDR_WIDTH-1:0]   memwb_rd_87,
  input  logic [DATA_WIDTH-1:0]       memwb_result_87,
  output logic                        stall_87,
  output logic                        ex_valid_87,
  output logic [DATA_WIDTH-1:0]       arg_a_87,
  output logic [DATA_WIDTH-1:0]       arg_b_87,
  output logic [1:0]                  op_87,
  output logic [FIELD_WIDTH_FUNC-1:0] fcn_87,
  output logic [DATA_WIDTH-1:0]       ex_store_data_87,
  output logic [REG_ADDR_WIDTH-1:0]   ex_wb_rd_87,
  output logic                        ex_reg_write_87,
  output logic                        ex_mem_read_87,
  output logic                        ex_mem_write_87,
  output logic                        ex_mem_to_reg_87,
  output logic [15:0]                 stall_count_87
);

  ex_reg_t               ex_q;
  ex_reg_t               ex_d;
  logic                  stall;
  logic [15:0]           stall_count_q;
  logic [DATA_WIDTH-1:0] rs_fwd;
  logic [DATA_WIDTH-1:0] rt_fwd;

  // Load-use hazard: the load in EX writes a register the decode instruction
  // reads. rt is compared even for I-type users; a spurious stall is harmless.
  always_comb begin
    stall = ex_q.valid && ex_q.mem_read && (ex_q.wb_rd != '0) && id_valid_87 &&
            ((ex_q.wb_rd == id_rs_87) || (ex_q.wb_rd == id_rt_87));
  end

  // Next register contents: the decode instruction, or a bubble when it is
  // idle, stalled or squashed (stall and flush together still give one bubble).
  always_comb begin
    ex_d = EX_BUBBLE;
    if (id_valid_87 && !stall && !flush_87) begin
      ex_d.valid      = 1'b1;
      ex_d.rs         = id_rs_87;
      ex_d.rt         = id_rt_87;
      ex_d.wb_rd      = id_reg_dst_87 ? id_rd_87 : id_rt_87;
      ex_d.rs_data    = id_rs_data_87;
      ex_d.rt_data    = id_rt_data_87;
      ex_d.imm        = id_imm_87;
      ex_d.op         = alu_op_e'(id_alu_op_87);
      ex_d.fcn        = id_fcn_87;
      ex_d.alu_src    = id_alu_src_87;
      ex_d.reg_write  = id_reg_write_87;
      ex_d.mem_read   = id_mem_read_87;
      ex_d.mem_write  = id_mem_write_87;
      ex_d.mem_to_reg = id_mem_to_reg_87;
    end
  end

  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87)
      ex_q <= EX_BUBBLE;
    else
      ex_q <= ex_d;
  end

  // Stall-cycle counter, pinned at all-ones instead of wrapping.
  always_ff @(posedge clk_87 or negedge rst_n_87) begin
    if (!rst_n_87)
      stall_count_q <= '0;
    else if (stall && (stall_count_q != 16'hFFFF))
      stall_count_q <= stall_count_q + 16'd1;
  end

  fwd_mux u_fwd_rs (
    .idx             (ex_q.rs),
    .reg_data        (ex_q.rs_data),
    .exmem_reg_write (exmem_reg_write_87),
    .exmem_rd        (exmem_rd_87),
    .exmem_result    (exmem_result_87),
    .memwb_reg_write (memwb_reg_write_87),
    .memwb_rd        (memwb_rd_87),
    .memwb_result    (memwb_result_87),
    .value           (rs_fwd)
  );

  fwd_mux u_fwd_rt (
    .idx             (ex_q.rt),
    .reg_data        (ex_q.rt_data),
    .exmem_reg_write (exmem_reg_write_87),
    .exmem_rd        (exmem_rd_87),
    .exmem_result    (exmem_result_87),
    .memwb_reg_write (memwb_reg_write_87),
    .memwb_rd        (memwb_rd_87),
    .memwb_result    (memwb_result_87),
    .value           (rt_fwd)
  );

  assign stall_87         = stall;
  assign ex_valid_87      = ex_q.valid;
  assign arg_a_87         = rs_fwd;
  assign arg_b_87         = ex_q.alu_src ? ex_q.imm : rt_fwd;
  assign op_87            = ex_q.op;
  assign fcn_87           = ex_q.fcn;
  assign ex_store_data_87 = rt_fwd;
  assign ex_wb_rd_87      = ex_q.wb_rd;
  assign ex_reg_write_87  = ex_q.reg_write;
  assign ex_mem_read_87   = ex_q.mem_read;
  assign ex_mem_write_87  = ex_q.mem_write;
  assign ex_mem_to_reg_87 = ex_q.mem_to_reg;
  assign stall_count_87   = stall_count_q;

endmodule

// File: tb/tb_id_ex_issue.sv
// tb_id_ex_issue
// Self-checking bench for id_ex_issue. Expected EX-stage outputs are pushed
// to a scoreboard queue when an instruction is presented and popped when the
// stage shows its result one cycle later.
module tb_id_ex_issue;
  import id_ex_issue_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [31:0] arg_a;
    logic [31:0] arg_b;
    logic [1:0]  op;
    logic [5:0]  fcn;
    logic [4:0]  wb_rd;
    logic [31:0] store_data;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } ex_out_t;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [1:0]  alu_op;
    logic [5:0]  fcn;
    logic        alu_src;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
  } instr_t;

  localparam ex_out_t BUBBLE = '0;

  logic        clk_87 = 1'b0;
  logic        rst_n_87 = 1'b1;
  logic        id_valid_87;
  logic [31:0] id_rs_data_87, id_rt_data_87, id_imm_87;
  logic [4:0]  id_rs_87, id_rt_87, id_rd_87;
  logic [1:0]  id_alu_op_87;
  logic [5:0]  id_fcn_87;
  logic        id_alu_src_87, id_reg_dst_87, id_reg_write_87;
  logic        id_mem_read_87, id_mem_write_87, id_mem_to_reg_87;
  logic        flush_87;
  logic        exmem_reg_write_87, memwb_reg_write_87;
  logic [4:0]  exmem_rd_87, memwb_rd_87;
  logic [31:0] exmem_result_87, memwb_result_87;
  logic        stall_87, ex_valid_87;
  logic [31:0] arg_a_87, arg_b_87, ex_store_data_87;
  logic [1:0]  op_87;
  logic [5:0]  fcn_87;
  logic [4:0]  ex_wb_rd_87;
  logic        ex_reg_write_87, ex_mem_read_87, ex_mem_write_87, ex_mem_to_reg_87;
  logic [15:0] stall_count_87;

  ex_out_t     obs;
  ex_out_t     exp_out;
  ex_out_t     sb[$];
  logic [15:0] exp_count;
  int          checks_total = 0;
  int          checks_passed = 0;

  assign obs = {ex_valid_87, arg_a_87, arg_b_87, op_87, fcn_87, ex_wb_rd_87,
                ex_store_data_87, ex_reg_write_87, ex_mem_read_87,
                ex_mem_write_87, ex_mem_to_reg_87};

  always #5 clk_87 = ~clk_87;

  id_ex_issue dut (
    .clk_87(clk_87), .rst_n_87(rst_n_87), .id_valid_87(id_valid_87),
    .id_rs_data_87(id_rs_data_87), .id_rt_data_87(id_rt_data_87),
    .id_imm_87(id_imm_87), .id_rs_87(id_rs_87), .id_rt_87(id_rt_87),
    .id_rd_87(id_rd_87), .id_alu_op_87(id_alu_op_87), .id_fcn_87(id_fcn_87),
    .id_alu_src_87(id_alu_src_87), .id_reg_dst_87(id_reg_dst_87),
    .id_reg_write_87(id_reg_write_87), .id_mem_read_87(id_mem_read_87),
    .id_mem_write_87(id_mem_write_87), .id_mem_to_reg_87(id_mem_to_reg_87),
    .flush_87(flush_87), .exmem_reg_write_87(exmem_reg_write_87),
    .exmem_rd_87(exmem_rd_87), .exmem_result_87(exmem_result_87),
    .memwb_reg_write_87(memwb_reg_write_87), .memwb_rd_87(memwb_rd_87),
    .memwb_result_87(memwb_result_87), .stall_87(stall_87),
    .ex_valid_87(ex_valid_87), .arg_a_87(arg_a_87), .arg_b_87(arg_b_87),
    .op_87(op_87), .fcn_87(fcn_87), .ex_store_data_87(ex_store_data_87),
    .ex_wb_rd_87(ex_wb_rd_87), .ex_reg_write_87(ex_reg_write_87),
    .ex_mem_read_87(ex_mem_read_87), .ex_mem_write_87(ex_mem_write_87),
    .ex_mem_to_reg_87(ex_mem_to_reg_87), .stall_count_87(stall_count_87)
  );

  // Instruction builders for the three formats used below.
  function automatic instr_t mk_rtype(input logic [4:0] rd, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [31:0] rsd,
                                      input logic [31:0] rtd, input logic [5:0] fcn);
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.rd = rd; i.rs = rs; i.rt = rt;
    i.rs_data = rsd; i.rt_data = rtd; i.alu_op = 2'b10; i.fcn = fcn;
    i.reg_dst = 1'b1; i.reg_write = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_lw(input logic [4:0] rt, input logic [4:0] rs,
                                   input logic [31:0] rsd, input logic [31:0] imm);
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.rt = rt; i.rs = rs; i.rs_data = rsd; i.imm = imm;
    i.alu_src = 1'b1; i.reg_write = 1'b1; i.mem_read = 1'b1; i.mem_to_reg = 1'b1;
    return i;
  endfunction

  function automatic instr_t mk_sw(input logic [4:0] rt, input logic [4:0] rs,
                                   input logic [31:0] rsd, input logic [31:0] rtd,
                                   input logic [31:0] imm);
    instr_t i;
    i = '0;
    i.valid = 1'b1; i.rt = rt; i.rs = rs; i.rs_data = rsd; i.rt_data = rtd;
    i.imm = imm; i.alu_src = 1'b1; i.mem_write = 1'b1;
    return i;
  endfunction

  // Reference model of the EX outputs for an issued instruction under the
  // forwarding inputs currently driven.
  function automatic ex_out_t predict(input instr_t i);
    ex_out_t     e;
    logic [31:0] rsv, rtv;
    e = '0;
    if (!i.valid) return e;
    rsv = i.rs_data;
    rtv = i.rt_data;
    if (i.rs != 0 && exmem_reg_write_87 && exmem_rd_87 == i.rs) rsv = exmem_result_87;
    else if (i.rs != 0 && memwb_reg_write_87 && memwb_rd_87 == i.rs) rsv = memwb_result_87;
    if (i.rt != 0 && exmem_reg_write_87 && exmem_rd_87 == i.rt) rtv = exmem_result_87;
    else if (i.rt != 0 && memwb_reg_write_87 && memwb_rd_87 == i.rt) rtv = memwb_result_87;
    e.valid = 1'b1;
    e.arg_a = rsv;
    e.arg_b = i.alu_src ? i.imm : rtv;
    e.op = i.alu_op;
    e.fcn = i.fcn;
    e.wb_rd = i.reg_dst ? i.rd : i.rt;
    e.store_data = rtv;
    e.reg_write = i.reg_write;
    e.mem_read = i.mem_read;
    e.mem_write = i.mem_write;
    e.mem_to_reg = i.mem_to_reg;
    return e;
  endfunction

  task automatic applyStimulus(input instr_t i);
    id_valid_87 = i.valid; id_rs_87 = i.rs; id_rt_87 = i.rt; id_rd_87 = i.rd;
    id_rs_data_87 = i.rs_data; id_rt_data_87 = i.rt_data; id_imm_87 = i.imm;
    id_alu_op_87 = i.alu_op; id_fcn_87 = i.fcn; id_alu_src_87 = i.alu_src;
    id_reg_dst_87 = i.reg_dst; id_reg_write_87 = i.reg_write;
    id_mem_read_87 = i.mem_read; id_mem_write_87 = i.mem_write;
    id_mem_to_reg_87 = i.mem_to_reg;
  endtask

  task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mr, input logic [31:0] mres);
    exmem_reg_write_87 = ew; exmem_rd_87 = er; exmem_result_87 = eres;
    memwb_reg_write_87 = mw; memwb_rd_87 = mr; memwb_result_87 = mres;
  endtask

  // Reset holds everything at zero even with live decode traffic.
  task automatic test_reset();
    instr_t add3;
    #1 rst_n_87 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_87);
      applyStimulus((c == 1) ? mk_lw(5'd5, 5'd1, 32'h100, 32'h8)
                             : mk_rtype(5'd3, 5'd1, 5'd2, 32'h5 + c, 32'h7, FUNCT_ADD));
      set_fwd(1'b1, 5'd1, 32'h1234, 1'b1, 5'd2, 32'h5678);
      #1;
      checks_total++;
      if (obs !== BUBBLE) $display("[TB] FAIL reset_out got %h expected %h", obs, BUBBLE);
      else checks_passed++;
      checks_total++;
      if (stall_87 !== 1'b0 || stall_count_87 !== 16'd0)
        $display("[TB] FAIL reset_stall got %b/%h expected 0/0000", stall_87, stall_count_87);
      else checks_passed++;
    end
    @(negedge clk_87);
    rst_n_87 = 1'b1;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    add3 = mk_rtype(5'd3, 5'd1, 5'd2, 32'd5, 32'd7, FUNCT_ADD);
    applyStimulus(add3);
    sb.push_back(predict(add3));
    @(negedge clk_87);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL first_add got %h expected %h", obs, exp_out);
    else checks_passed++;
    applyStimulus('0);
  endtask

  // EX/MEM beats MEM/WB beats the registered read, all combinationally.
  task automatic test_forward_priority();
    instr_t cur;
    string  names[4] = '{"fwd_exmem", "fwd_memwb", "fwd_none", "fwd_rt"};
    @(negedge clk_87);
    cur = mk_rtype(5'd8, 5'd4, 5'd9, 32'h44, 32'h99, FUNCT_SUB);
    applyStimulus(cur);
    @(negedge clk_87);
    applyStimulus('0);
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: set_fwd(1'b1, 5'd4, 32'h11, 1'b1, 5'd4, 32'h22);
        1: exmem_reg_write_87 = 1'b0;
        2: memwb_reg_write_87 = 1'b0;
        default: set_fwd(1'b1, 5'd9, 32'h33, 1'b0, 5'd4, 32'h22);
      endcase
      sb.push_back(predict(cur));
      #1;
      exp_out = sb.pop_front();
      checks_total++;
      if (obs !== exp_out) $display("[TB] FAIL %s got %h expected %h", names[k], obs, exp_out);
      else checks_passed++;
    end
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Writes targeting register 0 are never forwarded.
  task automatic test_reg_zero();
    instr_t z;
    @(negedge clk_87);
    set_fwd(1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF);
    z = mk_rtype(5'd10, 5'd0, 5'd0, 32'h0, 32'h0, FUNCT_OR);
    applyStimulus(z);
    sb.push_back(predict(z));
    @(negedge clk_87);
    applyStimulus('0);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL reg_zero got %h expected %h", obs, exp_out);
    else checks_passed++;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // lw $5 then add $6,$5,$1: one stall cycle, one bubble, then the add.
  // Second pass asserts reset during the stall.
  task automatic test_load_use();
    instr_t lw5, add6;
    lw5  = mk_lw(5'd5, 5'd1, 32'h100, 32'h8);
    add6 = mk_rtype(5'd6, 5'd5, 5'd1, 32'hBAD, 32'h100, FUNCT_ADD);
    @(negedge clk_87);
    applyStimulus(lw5);
    sb.push_back(predict(lw5));
    @(negedge clk_87);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL lu_load got %h expected %h", obs, exp_out);
    else checks_passed++;
    applyStimulus(add6);
    #1;
    checks_total++;
    if (stall_87 !== 1'b1) $display("[TB] FAIL lu_stall got %b expected 1", stall_87);
    else checks_passed++;
    sb.push_back(BUBBLE);
    @(negedge clk_87);
    exp_count = exp_count + 16'd1;
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL lu_bubble got %h expected %h", obs, exp_out);
    else checks_passed++;
    checks_total++;
    if (stall_87 !== 1'b0 || stall_count_87 !== exp_count)
      $display("[TB] FAIL lu_one_cycle got %b/%h expected 0/%h", stall_87, stall_count_87, exp_count);
    else checks_passed++;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h55);
    sb.push_back(predict(add6));
    @(negedge clk_87);
    applyStimulus('0);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL lu_add got %h expected %h", obs, exp_out);
    else checks_passed++;
    checks_total++;
    if (stall_count_87 !== exp_count)
      $display("[TB] FAIL lu_count got %h expected %h", stall_count_87, exp_count);
    else checks_passed++;

    applyStimulus(lw5);
    @(negedge clk_87);
    applyStimulus(add6);
    #1 rst_n_87 = 1'b0;
    #1;
    exp_count = 16'd0;
    checks_total++;
    if (stall_87 !== 1'b0 || stall_count_87 !== exp_count)
      $display("[TB] FAIL rst_mid_stall got %b/%h expected 0/%h", stall_87, stall_count_87, exp_count);
    else checks_passed++;
    #1 rst_n_87 = 1'b1;
    sb.push_back(predict(add6));
    @(negedge clk_87);
    applyStimulus('0);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL rst_release_add got %h expected %h", obs, exp_out);
    else checks_passed++;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // A flush coincident with a load-use stall yields exactly one bubble and
  // the squashed add never issues.
  task automatic test_flush_stall();
    @(negedge clk_87);
    applyStimulus(mk_lw(5'd5, 5'd1, 32'h200, 32'h4));
    @(negedge clk_87);
    applyStimulus(mk_rtype(5'd6, 5'd5, 5'd1, 32'h1, 32'h2, FUNCT_ADD));
    flush_87 = 1'b1;
    #1;
    checks_total++;
    if (stall_87 !== 1'b1) $display("[TB] FAIL fl_stall got %b expected 1", stall_87);
    else checks_passed++;
    sb.push_back(BUBBLE);
    @(negedge clk_87);
    exp_count = exp_count + 16'd1;
    flush_87 = 1'b0;
    applyStimulus('0);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL fl_bubble got %h expected %h", obs, exp_out);
    else checks_passed++;
    sb.push_back(BUBBLE);
    @(negedge clk_87);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out || stall_count_87 !== exp_count)
      $display("[TB] FAIL fl_no_issue got %h/%h expected %h/%h", obs, stall_count_87, exp_out, exp_count);
    else checks_passed++;
  endtask

  // Store: immediate on arg_b while the forwarded rt goes to store data.
  task automatic test_imm_store();
    instr_t sw7;
    @(negedge clk_87);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hAB);
    sw7 = mk_sw(5'd7, 5'd2, 32'h100, 32'h1, 32'hFFFF_FFFC);
    applyStimulus(sw7);
    sb.push_back(predict(sw7));
    @(negedge clk_87);
    applyStimulus('0);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL imm_store got %h expected %h", obs, exp_out);
    else checks_passed++;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Back-to-back random non-load traffic with idles, flushes and forwarding.
  task automatic test_back_to_back();
    instr_t i;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk_87);
      if (sb.size() != 0) begin
        exp_out = sb.pop_front();
        checks_total++;
        if (obs !== exp_out) $display("[TB] FAIL b2b_%0d got %h expected %h", n, obs, exp_out);
        else checks_passed++;
      end
      if ($urandom_range(0, 1) == 0)
        i = mk_rtype(5'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     $urandom, $urandom, 6'($urandom));
      else
        i = mk_sw(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      i.alu_op = 2'($urandom_range(0, 2));
      i.valid = ($urandom_range(0, 4) != 0);
      flush_87 = ($urandom_range(0, 6) == 0);
      set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
              1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      applyStimulus(i);
      sb.push_back(flush_87 ? BUBBLE : predict(i));
    end
    @(negedge clk_87);
    exp_out = sb.pop_front();
    checks_total++;
    if (obs !== exp_out) $display("[TB] FAIL b2b_last got %h expected %h", obs, exp_out);
    else checks_passed++;
    flush_87 = 1'b0;
    applyStimulus('0);
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  // Preload the counter near the top, then stall past it.
  task automatic test_saturation();
    @(negedge clk_87);
    force dut.stall_count_q = 16'hFFFD;
    #1 release dut.stall_count_q;
    exp_count = 16'hFFFD;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk_87);
      applyStimulus(mk_lw(5'd9, 5'd2, 32'h0, 32'h0));
      @(negedge clk_87);
      applyStimulus(mk_rtype(5'd4, 5'd3, 5'd9, 32'h0, 32'h0, FUNCT_AND));
      @(negedge clk_87);
      applyStimulus('0);
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      checks_total++;
      if (stall_count_87 !== exp_count)
        $display("[TB] FAIL sat_%0d got %h expected %h", s, stall_count_87, exp_count);
      else checks_passed++;
    end
    @(negedge clk_87);
    checks_total++;
    if (stall_count_87 !== 16'hFFFF)
      $display("[TB] FAIL sat_hold got %h expected ffff", stall_count_87);
    else checks_passed++;
  endtask

  initial begin
    applyStimulus('0);
    flush_87 = 1'b0;
    exp_count = 16'd0;
    set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    test_reset();
    test_forward_priority();
    test_reg_zero();
    test_load_use();
    test_flush_stall();
    test_imm_store();
    test_back_to_back();
    test_saturation();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("[TB] FAIL timeout got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/id_ex_issue.md
# id_ex_issue

ID/EX pipeline stage that drives the ALU: it registers decoded operands and controls, forwards results from EX/MEM and MEM/WB onto the ALU operand buses, and selects the immediate. It also detects load-use hazards, stalls upstream and inserts bubbles, and counts stall cycles. It sits between the decode stage and the ALU, and is the producer side of the ALU's `arg_a/arg_b/op/fcn` interface.

## Interface
- `DATA_WIDTH`, 32, operand width (from `mips_defs.vh`)
- `FIELD_WIDTH_FUNC`, 6, funct field width
- `REG_ADDR_WIDTH`, 5, register index width
- `clk_87` in 1: rising-edge clock
- `rst_n_87` in 1: reset, asynchronous, active-low
- `id_valid_87` in 1: decode stage holds a real instruction
- `id_rs_data_87`, `id_rt_data_87`, `id_imm_87` in DATA_WIDTH: register reads; sign-extended immediate
- `id_rs_87`, `id_rt_87`, `id_rd_87` in REG_ADDR_WIDTH: register indices
- `id_alu_op_87` in 2: 00 add, 01 sub, 10 R-type by funct
- `id_fcn_87` in FIELD_WIDTH_FUNC: funct code
- `id_alu_src_87`, `id_reg_dst_87`, `id_reg_write_87`, `id_mem_read_87`, `id_mem_write_87`, `id_mem_to_reg_87` in 1 each: decoded controls
- `flush_87` in 1: squash the ID instruction (taken branch)
- `exmem_reg_write_87` in 1, `exmem_rd_87` in REG_ADDR_WIDTH, `exmem_result_87` in DATA_WIDTH: EX/MEM forward source
- `memwb_reg_write_87` in 1, `memwb_rd_87` in REG_ADDR_WIDTH, `memwb_result_87` in DATA_WIDTH: MEM/WB forward source
- `stall_87` out 1: hold PC and IF/ID
- `ex_valid_87` out 1: the EX instruction is real
- `arg_a_87`, `arg_b_87` out DATA_WIDTH: ALU operands
- `op_87` out 2, `fcn_87` out FIELD_WIDTH_FUNC: ALU control
- `ex_store_data_87` out DATA_WIDTH: forwarded rt value for stores
- `ex_wb_rd_87` out REG_ADDR_WIDTH: destination register
- `ex_reg_write_87`, `ex_mem_read_87`, `ex_mem_write_87`, `ex_mem_to_reg_87` out 1 each: downstream controls
- `stall_count_87` out 16: saturating count of stall cycles

## Operation
- **Load-use hazard.** `stall_87` is combinational. It is 1 when all of these hold:
  - `ex_valid_q` and `ex_mem_read_q`
  - `ex_wb_rd_q != 0`
  - `id_valid_87`
  - `ex_wb_rd_q` equals `id_rs_87` or `id_rt_87`; rt is compared unconditionally.
- **Capture.** At each edge the register captures the ID fields only when `id_valid_87 & !stall_87 & !flush_87`.
- **Bubble.** Otherwise the edge loads a bubble:
  - valid and all control bits 0
  - `op` 00, `fcn` 0, indices 0, data 0
- **Flush and stall together.** A flush coincident with a stall produces a single bubble.
- **Destination.** `ex_wb_rd` is captured as `id_reg_dst ? id_rd : id_rt`.
- **Forwarding.** Each of `rs_q` and `rt_q` selects its value in this priority:
  1. `exmem_result` when `exmem_reg_write` and `exmem_rd == idx` and `idx != 0`
  2. `memwb_result` under the same conditions on the MEM/WB fields
  3. the registered read data
- **Operands.** `arg_a` is the forwarded rs value. `arg_b` is `imm_q` when `alu_src_q`, otherwise the forwarded rt value. `ex_store_data` is always the forwarded rt value.
- **Register 0.** Never forwarded.
- **Stall counter.** `stall_count` increments on each edge where `stall_87 == 1` and saturates at 0xFFFF.

## Timing
- **Reset.** Asserting `rst_n_87` low clears every register immediately. While in reset:
  - `ex_valid` and all controls are 0
  - `op` = 00, `fcn` = 0, `ex_wb_rd` = 0
  - `arg_a`, `arg_b`, `ex_store_data` = 0
  - `stall_count` = 0
  - `stall_87` = 0
- Reset asserted mid-stall drops the stall the same cycle. The first edge after release captures normally.
- **Latency.** An ID instruction appears on the EX outputs one cycle after capture.
- **Forwarding paths.** Combinational, same cycle as the EX/MEM and MEM/WB inputs.
- **Stall length.** A load-use stall lasts exactly one cycle: the bubble clears `ex_mem_read_q`. The held instruction is captured on the following edge.
- **Idle upstream.** `id_valid_87 = 0` never raises a stall and yields a bubble.

## Structure
- **`mips_defs.vh`:**
  - `DATA_WIDTH`, `FIELD_WIDTH_FUNC`, `REG_ADDR_WIDTH`
  - `ALUOP_ADD` = 00, `ALUOP_SUB` = 01, `ALUOP_RTYPE` = 10
- **`alu.vh`:** funct codes.
- **`fwd_mux`:** one sub-module for the priority forwarding select, instantiated twice (rs and rt).
- **`id_ex_issue` itself:** the pipeline register, hazard logic and counter.

## Test plan
- **Reset.** Hold `rst_n_87` = 0 with ID inputs toggling -> all outputs 0 and `stall_count` 0. Release, then present `add $3,$1,$2` with rs_data 5, rt_data 7 -> next cycle `arg_a` = 5, `arg_b` = 7, `op` = 10, `fcn` = 0x20, `ex_wb_rd` = 3.
- **Forward priority.** EX has rs = 4. Drive `exmem` rd 4 = 0x11 and `memwb` rd 4 = 0x22 -> `arg_a` = 0x11. Drop `exmem_reg_write` -> `arg_a` = 0x22.
- **Register 0.** `exmem` rd 0 with write = 1, EX rs = 0, registered data 0 -> `arg_a` = 0.
- **Load-use.** `lw $5` in EX followed by `add $6,$5,$1` in ID -> `stall_87` = 1 for exactly one cycle, then a bubble (`ex_valid` = 0). The add issues the next cycle, and `stall_count` = 1.
- **Flush during stall.** Same setup as load-use with `flush_87` = 1 -> a single bubble, and the add is not issued unless re-presented.
- **Immediate and counter saturation.**
  - `sw` with `alu_src` = 1, imm 0xFFFFFFFC, rt forwarded from `memwb` = 0xAB -> `arg_b` = 0xFFFFFFFC, `ex_store_data` = 0xAB.
  - Force 65536 stall cycles -> `stall_count` holds at 0xFFFF.
